// File: rtl/spe_dwc_lane_pipe.sv
// spe_dwc_lane_pipe: 4-stage per-lane batch-norm + activation pipeline with valid/ready backpressure
module spe_dwc_lane_pipe #(
  parameter int LANE_WIDTH = 8,
  parameter int LANE_NUM = 4,
  parameter int RELU6_MAX = 6,
  localparam int DATA_WIDTH = LANE_WIDTH * LANE_NUM
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0] alpha,
  input  logic [DATA_WIDTH-1:0] beta,
  input  logic                  have_batch,
  input  logic                  batch_first,
  input  logic [1:0]            act_mode,
  input  logic [5:0]            quant_norm,
  input  logic [3:0]            quant_pe,
  input  logic [2:0]            leaky_shift,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  idle
);
  localparam int W = LANE_WIDTH;
  function automatic logic [W-1:0] bn_op(input logic [W-1:0] x, a, b, input logic [5:0] qn);
    logic signed [2*W-1:0] p, s;
    logic [2*W:0] r;
    p = {{W{x[W-1]}}, x} * {{W{a[W-1]}}, a};
    s = p >>> qn;
    r = {s[2*W-1], s} + {{(W+1){b[W-1]}}, b};
    return (&r[2*W:W-1] | ~|r[2*W:W-1]) ? r[W-1:0] : {r[2*W], {(W-1){~r[2*W]}}};
  endfunction
  function automatic logic [W-1:0] act_op(input logic [W-1:0] x, input logic [1:0] am,
                                          input logic [3:0] qp, input logic [2:0] ls);
    logic [31:0] c;
    c = 32'(RELU6_MAX) << qp;
    return am == 2'd0 ? x :
           !x[W-1] ? ((am == 2'd2 && 32'(x) > c) ? c[W-1:0] : x) :
           am == 2'd3 ? W'($signed(x) >>> ls) : '0;
  endfunction
  // cfg layout: [16] have_batch, [15] batch_first, [14:13] act_mode, [12:7] quant_norm, [6:3] quant_pe, [2:0] leaky_shift
  function automatic logic [W-1:0] stage_op(input logic [W-1:0] x, a, b, input logic [16:0] cfg, input logic bn_now);
    return bn_now ? (cfg[16] ? bn_op(x, a, b, cfg[12:7]) : x) : act_op(x, cfg[14:13], cfg[6:3], cfg[2:0]);
  endfunction
  logic [3:0]            r_v;
  logic [DATA_WIDTH-1:0] r_d1, r_d2, r_d3, r_d4, r_a1, r_a2, r_b1, r_b2;
  logic [16:0]           r_c1, r_c2;
  logic [DATA_WIDTH-1:0] w_d2, w_d3;
  logic                  w_en;
  assign w_en      = !r_v[3] | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v[3];
  assign out_data  = r_d4;
  assign idle      = ~|r_v;
  // S2 runs BN first when batch_first, S3 runs whichever operator S2 did not
  always_comb begin
    w_d2 = '0;
    w_d3 = '0;
    for (int k = 0; k < LANE_NUM; k++) begin
      w_d2[k*W +: W] = stage_op(r_d1[k*W +: W], r_a1[k*W +: W], r_b1[k*W +: W], r_c1, r_c1[15]);
      w_d3[k*W +: W] = stage_op(r_d2[k*W +: W], r_a2[k*W +: W], r_b2[k*W +: W], r_c2, !r_c2[15]);
    end
  end
  // whole pipeline advances together; a full output stage with no taker freezes every stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v  <= '0;
      r_d1 <= '0;
      r_d2 <= '0;
      r_d3 <= '0;
      r_d4 <= '0;
      r_a1 <= '0;
      r_a2 <= '0;
      r_b1 <= '0;
      r_b2 <= '0;
      r_c1 <= '0;
      r_c2 <= '0;
    end else if (w_en) begin
      r_v  <= {r_v[2:0], in_valid};
      r_d1 <= in_data;
      r_a1 <= alpha;
      r_b1 <= beta;
      r_c1 <= {have_batch, batch_first, act_mode, quant_norm, quant_pe, leaky_shift};
      r_d2 <= w_d2;
      r_a2 <= r_a1;
      r_b2 <= r_b1;
      r_c2 <= r_c1;
      r_d3 <= w_d3;
      r_d4 <= r_d3;
    end
  end
endmodule

// File: tb/tb_spe_dwc_lane_pipe.sv
// tb_spe_dwc_lane_pipe: directed checks of BN/activation results, latency, backpressure and reset
module tb_spe_dwc_lane_pipe;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 0, idle;
  logic [31:0] in_data = 0, alpha = 0, beta = 0, out_data;
  logic        have_batch = 0, batch_first = 0;
  logic [1:0]  act_mode = 0;
  logic [5:0]  quant_norm = 0;
  logic [3:0]  quant_pe = 0;
  logic [2:0]  leaky_shift = 0;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  spe_dwc_lane_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .alpha(alpha), .beta(beta), .have_batch(have_batch), .batch_first(batch_first),
    .act_mode(act_mode), .quant_norm(quant_norm), .quant_pe(quant_pe), .leaky_shift(leaky_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .idle(idle)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic set_beat(input logic [31:0] d, a, b, input logic hb, bf, input logic [1:0] am,
                          input logic [5:0] qn, input logic [3:0] qp, input logic [2:0] ls);
    in_data = d; alpha = a; beta = b; have_batch = hb; batch_first = bf;
    act_mode = am; quant_norm = qn; quant_pe = qp; leaky_shift = ls;
  endtask
  task automatic run(input string tag, input logic [31:0] exp);
    int lat;
    @(negedge clk); in_valid = 1; out_ready = 1; #1;
    chk({tag, "_idle_pre"}, idle, 1);
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk); in_valid = 0; #1;
    chk({tag, "_idle_busy"}, idle, 0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_data"}, out_data, exp);
    @(negedge clk); #1;
    chk({tag, "_idle_post"}, idle, 1);
  endtask
  initial begin
    int sent, got, cyc, extra;
    #1;
    chk("rst_idle", idle, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    set_beat(32'h80F01234, 0, 0, 0, 1, 2'd0, 0, 0, 0);                      run("bypass", 32'h80F01234);
    set_beat(32'h7020F060, 0, 0, 0, 1, 2'd2, 0, 4, 0);                      run("relu6_q4", 32'h60200060);
    set_beat(32'h7020F060, 0, 0, 0, 1, 2'd2, 0, 5, 0);                      run("relu6_q5", 32'h70200060);
    set_beat(32'h10101010, 32'h03030303, 32'hFBFBFBFB, 1, 1, 2'd0, 2, 0, 0); run("bn_basic", 32'h07070707);
    set_beat(32'h00059C64, 32'h64026464, 32'h0, 1, 1, 2'd0, 0, 0, 0);        run("bn_sat", 32'h000A807F);
    set_beat(32'h01FF01FF, 32'h01010101, 32'h7F00007F, 1, 1, 2'd0, 40, 0, 0); run("bn_bigshift", 32'h7FFF007E);
    set_beat(32'hF0F0F0F0, 32'hFEFEFEFE, 32'h0, 1, 1, 2'd1, 0, 0, 0);        run("order_bn_first", 32'h20202020);
    set_beat(32'hF0F0F0F0, 32'hFEFEFEFE, 32'h0, 1, 0, 2'd1, 0, 0, 0);        run("order_act_first", 32'h00000000);
    set_beat(32'h02020202, 32'h03030303, 32'h05050505, 1, 0, 2'd1, 1, 0, 0); run("act_then_bn", 32'h08080808);
    set_beat(32'hF710FFF0, 0, 0, 0, 1, 2'd3, 0, 0, 3);                      run("leaky", 32'hFE10FFFE);
    set_beat(32'h7F80017F, 0, 0, 0, 1, 2'd1, 0, 0, 0);                      run("relu", 32'h7F00017F);
    set_beat(0, 0, 0, 0, 1, 2'd0, 0, 0, 0);
    sent = 0; got = 0; cyc = 0;
    while (got < 10 && cyc < 300) begin
      @(negedge clk);
      in_valid = sent < 10;
      in_data = 32'h10000000 + 32'(sent) * 32'h01030507;
      out_ready = (cyc >= 6 && cyc <= 9) ? 1'b0 : (cyc < 6 ? 1'b1 : 1'($urandom_range(0, 1)));
      #1;
      chk("bp_in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        chk("bp_data", out_data, 32'h10000000 + 32'(got) * 32'h01030507);
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    chk("bp_count", got, 10);
    in_valid = 0; out_ready = 1; extra = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (out_valid) extra++;
    end
    chk("bp_no_dup", extra, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_data = 32'hA5000001 + 32'(i);
      in_valid = 1;
    end
    @(negedge clk); in_valid = 0; #1;
    chk("rst_pre_out_valid", out_valid, 1);
    rst_n = 0; #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_out_data", out_data, 0);
    chk("rst_mid_idle", idle, 1);
    @(negedge clk); rst_n = 1;
    extra = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (out_valid) extra++;
    end
    chk("rst_no_stale", extra, 0);
    chk("rst_idle_after", idle, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
